// File: rtl/cpu_reg_package.sv
// cpu_reg_package
//  Shared definitions for the CPU register bus: bus widths, the module_bus
//  index enum, the address window table with its lookup functions, and the
//  types used by the bus handshake responders.
//  No ports (package).
package cpu_reg_package;

  localparam int address_width = 32;
  localparam int data_width    = 32;

  // One entry per peripheral window on the CPU bus.
  typedef enum logic [1:0] {
    gpio_e,
    uart_e,
    io_e,
    timer_e
  } module_bus_e;

  localparam int num_modules = 4;

  // Read-data return slots, one per module_bus entry.
  typedef logic [data_width-1:0] data_reg_inputs_t [num_modules];

  // Responder handshake states.
  typedef enum logic {
    RESP_IDLE,
    RESP_WAIT_ACK
  } resp_state_t;

  // Read data returned when the user logic never answers.
  localparam logic [data_width-1:0] RESP_ERROR_DATA = 32'hDEAD_BEEF;

  // First byte address of a module window (inclusive).
  function automatic logic [address_width-1:0] get_address_start(input module_bus_e entry);
    logic [address_width-1:0] addr;
    addr = '0;
    case (entry)
      gpio_e:  addr = 32'h0000_8000;
      uart_e:  addr = 32'h0000_8800;
      io_e:    addr = 32'h0000_9000;
      timer_e: addr = 32'h0000_9800;
      default: addr = '0;
    endcase
    return addr;
  endfunction

  // Last byte address of a module window (inclusive).
  function automatic logic [address_width-1:0] get_address_end(input module_bus_e entry);
    logic [address_width-1:0] addr;
    addr = '0;
    case (entry)
      gpio_e:  addr = 32'h0000_80FF;
      uart_e:  addr = 32'h0000_880F;
      io_e:    addr = 32'h0000_900C;
      timer_e: addr = 32'h0000_981F;
      default: addr = '0;
    endcase
    return addr;
  endfunction

endpackage

// File: rtl/bus_window_decode.sv
// bus_window_decode
//  Combinational address decode for one module_bus window. Shared by every
//  bus handshake responder so all of them agree on window bounds.
//  Parameters:
//    MODULE_ENTRY  module_bus index whose window is decoded
//  Ports:
//    addr    in   address_width  CPU byte address
//    hit     out  1              addr lies inside [start, end] inclusive
//    offset  out  address_width  addr - window start (meaningful when hit)
module bus_window_decode
  import cpu_reg_package::*;
#(
  parameter module_bus_e MODULE_ENTRY = io_e
) (
  input  logic [address_width-1:0] addr,
  output logic                     hit,
  output logic [address_width-1:0] offset
);

  localparam logic [address_width-1:0] WIN_START = get_address_start(MODULE_ENTRY);
  localparam logic [address_width-1:0] WIN_END   = get_address_end(MODULE_ENTRY);

  assign hit    = (addr >= WIN_START) && (addr <= WIN_END);
  assign offset = addr - WIN_START;

endmodule

// File: rtl/bus_handshake_responder.sv
// bus_handshake_responder
//  Bus-side responder for one module_bus address window. A CPU read or write
//  strobe that hits the window is turned into a level req/ack handshake toward
//  fabric user logic; the CPU is stalled until the user logic acks, and read
//  data is returned on a registered bus_rdata_o.
//  Optional feature: define BUS_RESP_TIMEOUT_EN to abort a transaction after
//  TIMEOUT_CYCLES cycles without ack (returns ERROR_DATA on reads, sets the
//  sticky err_o and bumps the saturating err_count_o). Without the macro the
//  responder waits for ack indefinitely and err_o / err_count_o are 0.
//  Parameters:
//    MODULE_ENTRY    module_bus index served
//    TIMEOUT_CYCLES  cycles allowed in WAIT_ACK before abort (>= 2)
//    ERROR_DATA      read data returned on timeout
//  Ports:
//    clk_i         in   system clock
//    reset_n_i     in   synchronous active-low reset
//    bus_addr_i    in   CPU byte address
//    bus_wdata_i   in   CPU write data
//    bus_we_i      in   write strobe (wins if both strobes are high)
//    bus_re_i      in   read strobe
//    bus_rdata_o   out  registered read data
//    bus_stall_o   out  CPU wait request
//    usr_req_o     out  level request to user logic
//    usr_we_o      out  1 = write, 0 = read, stable while usr_req_o
//    usr_offset_o  out  byte offset into the window, stable while usr_req_o
//    usr_wdata_o   out  write data, stable while usr_req_o
//    usr_ack_i     in   single-cycle completion from user logic
//    usr_rdata_i   in   read data, valid with usr_ack_i
//    err_o         out  sticky timeout flag
//    err_clr_i     in   clears err_o and err_count_o
//    err_count_o   out  saturating timeout count
module bus_handshake_responder
  import cpu_reg_package::*;
#(
  parameter module_bus_e               MODULE_ENTRY   = io_e,
  parameter int                        TIMEOUT_CYCLES = 64,
  parameter logic [data_width-1:0]     ERROR_DATA     = RESP_ERROR_DATA
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic [address_width-1:0] bus_addr_i,
  input  logic [data_width-1:0]    bus_wdata_i,
  input  logic                     bus_we_i,
  input  logic                     bus_re_i,
  output logic [data_width-1:0]    bus_rdata_o,
  output logic                     bus_stall_o,
  output logic                     usr_req_o,
  output logic                     usr_we_o,
  output logic [address_width-1:0] usr_offset_o,
  output logic [data_width-1:0]    usr_wdata_o,
  input  logic                     usr_ack_i,
  input  logic [data_width-1:0]    usr_rdata_i,
  output logic                     err_o,
  input  logic                     err_clr_i,
  output logic [7:0]               err_count_o
);

  resp_state_t                state;
  resp_state_t                next_state;
  logic                       hit;
  logic [address_width-1:0]   offset;
  logic                       strobe;
  logic                       accept;
  logic                       ack_done;
  logic                       timeout;

  bus_window_decode #(
    .MODULE_ENTRY(MODULE_ENTRY)
  ) u_decode (
    .addr  (bus_addr_i),
    .hit   (hit),
    .offset(offset)
  );

  assign strobe   = bus_we_i | bus_re_i;
  assign accept   = (state == RESP_IDLE) && hit && strobe;
  assign ack_done = (state == RESP_WAIT_ACK) && usr_ack_i;

`ifdef BUS_RESP_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_count;

  // wait_count is 0 in the first WAIT_ACK cycle, so reaching TIMEOUT_LAST
  // means TIMEOUT_CYCLES cycles have been spent waiting. An ack on that same
  // cycle is a normal completion, hence the !usr_ack_i term.
  assign timeout = (state == RESP_WAIT_ACK) && !usr_ack_i && (wait_count == TIMEOUT_LAST);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wait_count <= '0;
    end else if (accept) begin
      wait_count <= '0;
    end else if (state == RESP_WAIT_ACK) begin
      wait_count <= wait_count + 16'd1;
    end
  end

  // Clear beats a simultaneous timeout so software never loses a clear.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else if (err_clr_i) begin
      err_o       <= 1'b0;
      err_count_o <= '0;
    end else if (timeout) begin
      err_o <= 1'b1;
      if (err_count_o != 8'hFF) begin
        err_count_o <= err_count_o + 8'd1;
      end
    end
  end
`else
  localparam int                    unused_timeout_cycles = TIMEOUT_CYCLES;
  localparam logic [data_width-1:0] unused_error_data     = ERROR_DATA;

  logic unused_err_clr;

  assign unused_err_clr = err_clr_i;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
  assign err_count_o    = '0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state <= RESP_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Stall is combinational so the CPU is held in the very cycle of the
  // strobe; req only rises once the operands are latched.
  always_comb begin
    next_state  = state;
    bus_stall_o = 1'b0;
    usr_req_o   = 1'b0;
    case (state)
      RESP_IDLE: begin
        if (hit && strobe) begin
          bus_stall_o = 1'b1;
          next_state  = RESP_WAIT_ACK;
        end
      end
      RESP_WAIT_ACK: begin
        bus_stall_o = 1'b1;
        usr_req_o   = 1'b1;
        if (usr_ack_i || timeout) begin
          next_state = RESP_IDLE;
        end
      end
      default: next_state = RESP_IDLE;
    endcase
  end

  // Operands are captured only when a transaction is accepted, which keeps
  // them stable for the whole request even if the CPU bus changes.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      usr_offset_o <= '0;
      usr_wdata_o  <= '0;
      usr_we_o     <= 1'b0;
    end else if (accept) begin
      usr_offset_o <= offset;
      usr_wdata_o  <= bus_wdata_i;
      usr_we_o     <= bus_we_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      bus_rdata_o <= '0;
    end else if (ack_done && !usr_we_o) begin
      bus_rdata_o <= usr_rdata_i;
    end else if (timeout && !usr_we_o) begin
      bus_rdata_o <= ERROR_DATA;
    end
  end

endmodule

// File: tb/tb_bus_handshake_responder.sv
// tb_bus_handshake_responder
//  Self-checking bench for bus_handshake_responder (io_e window 0x9000..0x900C).
//  Expected user-side operands are pushed to a scoreboard queue when a strobe
//  is driven and popped when the DUT raises usr_req_o. Timeout scenarios are
//  exercised only when BUS_RESP_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module tb_bus_handshake_responder;
  import cpu_reg_package::*;

  localparam int          TIMEOUT   = 8;
  localparam logic [31:0] WIN_START = 32'h0000_9000;
  localparam logic [31:0] WIN_END   = 32'h0000_900C;
  localparam logic [31:0] ERR_DATA  = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic        bus_we = 1'b0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic        bus_stall;
  logic        usr_req;
  logic        usr_we;
  logic [31:0] usr_offset;
  logic [31:0] usr_wdata;
  logic        usr_ack = 1'b0;
  logic [31:0] usr_rdata = '0;
  logic        err;
  logic        err_clr = 1'b0;
  logic [7:0]  err_count;

  typedef struct {
    logic        we;
    logic [31:0] offset;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          req_count = 0;
  int          exp_req_count = 0;
  logic [31:0] model_rdata = '0;

  bus_handshake_responder #(
    .MODULE_ENTRY  (io_e),
    .TIMEOUT_CYCLES(TIMEOUT),
    .ERROR_DATA    (ERR_DATA)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n),
    .bus_addr_i  (bus_addr),
    .bus_wdata_i (bus_wdata),
    .bus_we_i    (bus_we),
    .bus_re_i    (bus_re),
    .bus_rdata_o (bus_rdata),
    .bus_stall_o (bus_stall),
    .usr_req_o   (usr_req),
    .usr_we_o    (usr_we),
    .usr_offset_o(usr_offset),
    .usr_wdata_o (usr_wdata),
    .usr_ack_i   (usr_ack),
    .usr_rdata_i (usr_rdata),
    .err_o       (err),
    .err_clr_i   (err_clr),
    .err_count_o (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge usr_req) req_count++;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // Drives one CPU access and plays the user logic. ack_delay is the number of
  // WAIT_ACK cycles before the ack cycle; a negative value never acks.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic we, input logic re, input int ack_delay,
                               input logic [31:0] ack_data, input bit extra_strobe);
    bit   hit;
    exp_t e;
    int   stall_cycles;
    int   exp_stall;
    int   d;
    int   guard;

    hit = (addr >= WIN_START) && (addr <= WIN_END) && (we || re);
    exp_stall = 0;
    e.we = 1'b0;
    e.offset = '0;
    e.wdata = '0;
    if (hit) begin
      e.we     = we;
      e.offset = addr - WIN_START;
      e.wdata  = wdata;
      sb.push_back(e);
      exp_req_count++;
      if (!we) model_rdata = (ack_delay < 0) ? ERR_DATA : ack_data;
      exp_stall = (ack_delay < 0) ? TIMEOUT + 1 : ack_delay + 2;
    end

    @(negedge clk);
    bus_addr = addr; bus_wdata = wdata; bus_we = we; bus_re = re;
    #1;
    checkOutput("stall_on_strobe", {31'd0, bus_stall}, {31'd0, hit});
    stall_cycles = bus_stall ? 1 : 0;

    @(negedge clk);
    bus_we = 1'b0; bus_re = 1'b0;
    #1;
    if (!hit) begin
      checkOutput("miss_no_stall", {31'd0, bus_stall}, 32'd0);
      checkOutput("miss_no_req", {31'd0, usr_req}, 32'd0);
      return;
    end

    checkOutput("req_high", {31'd0, usr_req}, 32'd1);
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      checkOutput("usr_offset", usr_offset, e.offset);
      checkOutput("usr_we", {31'd0, usr_we}, {31'd0, e.we});
      if (e.we) checkOutput("usr_wdata", usr_wdata, e.wdata);
    end
    if (bus_stall) stall_cycles++;
    if (ack_delay == 0) begin usr_ack = 1'b1; usr_rdata = ack_data; end

    d = 0;
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      usr_ack = 1'b0; bus_re = 1'b0;
      d++; guard++;
      #1;
      if (!bus_stall) break;
      stall_cycles++;
      if (extra_strobe && d == 1) begin bus_addr = WIN_START + 32'd4; bus_re = 1'b1; end
      if (d == ack_delay) begin usr_ack = 1'b1; usr_rdata = ack_data; end
    end

    checkOutput("stall_release_bound", {31'd0, guard < 200}, 32'd1);
    checkOutput("stall_cycles", stall_cycles, exp_stall);
    checkOutput("req_dropped", {31'd0, usr_req}, 32'd0);
    checkOutput("bus_rdata", bus_rdata, model_rdata);
    checkOutput("offset_held", usr_offset, e.offset);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Reset state
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_rdata", bus_rdata, 32'd0);
    checkOutput("rst_stall", {31'd0, bus_stall}, 32'd0);
    checkOutput("rst_req", {31'd0, usr_req}, 32'd0);
    checkOutput("rst_we", {31'd0, usr_we}, 32'd0);
    checkOutput("rst_offset", usr_offset, 32'd0);
    checkOutput("rst_wdata", usr_wdata, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    checkOutput("rst_err_count", {24'd0, err_count}, 32'd0);
    reset_n = 1'b1;

    $display("[TB] read 0x9008, ack after 3 cycles");
    applyStimulus(32'h0000_9008, 32'h0, 1'b0, 1'b1, 3, 32'h1234_5678, 1'b0);

    $display("[TB] write 0x9004, immediate ack");
    applyStimulus(32'h0000_9004, 32'hA5A5_0001, 1'b1, 1'b0, 0, 32'h5555_5555, 1'b0);

    $display("[TB] window boundaries");
    applyStimulus(32'h0000_9010, 32'h0, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    applyStimulus(32'h0000_8FFC, 32'h0, 1'b0, 1'b1, 0, 32'h0, 1'b0);
    applyStimulus(32'h0000_900C, 32'h0, 1'b0, 1'b1, 1, 32'h0BAD_F00D, 1'b0);
    applyStimulus(32'h0000_9000, 32'h0000_0077, 1'b1, 1'b1, 2, 32'h7777_7777, 1'b0);

    $display("[TB] strobe during WAIT_ACK and spurious ack in IDLE");
    applyStimulus(32'h0000_9008, 32'h0, 1'b0, 1'b1, 3, 32'h0F0F_1234, 1'b1);
    @(negedge clk);
    usr_ack = 1'b1; usr_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    usr_ack = 1'b0;
    #1;
    checkOutput("spurious_ack_req", {31'd0, usr_req}, 32'd0);
    checkOutput("spurious_ack_stall", {31'd0, bus_stall}, 32'd0);
    checkOutput("spurious_ack_rdata", bus_rdata, model_rdata);
    checkOutput("req_count", req_count, exp_req_count);

`ifdef BUS_RESP_TIMEOUT_EN
    $display("[TB] timeout with no ack");
    applyStimulus(32'h0000_9004, 32'h0, 1'b0, 1'b1, -1, 32'h0, 1'b0);
    checkOutput("timeout_err", {31'd0, err}, 32'd1);
    checkOutput("timeout_err_count", {24'd0, err_count}, 32'd1);
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    checkOutput("err_clr_err", {31'd0, err}, 32'd0);
    checkOutput("err_clr_count", {24'd0, err_count}, 32'd0);
`else
    checkOutput("err_tied_off", {31'd0, err}, 32'd0);
    checkOutput("err_count_tied_off", {24'd0, err_count}, 32'd0);
`endif

    $display("[TB] reset during WAIT_ACK");
    @(negedge clk);
    bus_addr = 32'h0000_9008; bus_wdata = 32'h1111_2222; bus_we = 1'b1;
    exp_req_count++;
    @(negedge clk);
    bus_we = 1'b0;
    #1;
    checkOutput("abort_req_high", {31'd0, usr_req}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    model_rdata = '0;
    checkOutput("abort_rdata", bus_rdata, 32'd0);
    checkOutput("abort_stall", {31'd0, bus_stall}, 32'd0);
    checkOutput("abort_req", {31'd0, usr_req}, 32'd0);
    checkOutput("abort_we", {31'd0, usr_we}, 32'd0);
    checkOutput("abort_offset", usr_offset, 32'd0);
    checkOutput("abort_wdata", usr_wdata, 32'd0);
    reset_n = 1'b1;
    applyStimulus(32'h0000_9000, 32'h0, 1'b0, 1'b1, 1, 32'hCAFE_F00D, 1'b0);

    checkOutput("final_req_count", req_count, exp_req_count);
    checkOutput("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
